// File: rtl/shifter_pkg.sv
// Shared types for the ARM data-processing shifter: shift-type codes and the
// stage-1 operation classes handed from the decoder to the shift stage.
package shifter_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_e;

   typedef enum logic [2:0] {
      PASS,
      SHIFT,
      FULL32,
      OVER32,
      RRX,
      ROR0
   } shift_cls_e;

endpackage

// File: rtl/shift_decode.sv
// Combinational stage-1 classifier: maps amount/type/encoding onto an
// operation class plus a 5-bit shift count for the shift stage.
module shift_decode
   import shifter_pkg::*;
#(
   parameter int unsigned AMT_W = 8
) (
   input  logic [AMT_W-1:0] amount,
   input  logic [1:0]       shift_type,
   input  logic             imm_form,
   output shift_cls_e       cls,
   output logic [4:0]       count
);

   shift_type_e sh_type;

   always_comb begin
      sh_type = shift_type_e'(shift_type);
      cls     = PASS;
      count   = amount[4:0];
      if (imm_form) begin
         // #0 in the immediate encoding is reinterpreted per shift type
         if (amount[4:0] == 5'd0) begin
            case (sh_type)
               SH_LSL:  cls = PASS;
               SH_LSR:  cls = FULL32;
               SH_ASR:  cls = FULL32;
               SH_ROR:  cls = RRX;
               default: cls = PASS;
            endcase
         end else begin
            cls = SHIFT;
         end
      end else if (amount == '0) begin
         cls = PASS;
      end else if (sh_type == SH_ROR) begin
         cls = (amount[4:0] == 5'd0) ? ROR0 : SHIFT;
      end else if (amount < AMT_W'(32)) begin
         cls = SHIFT;
      end else if (amount == AMT_W'(32)) begin
         cls = FULL32;
      end else begin
         cls = (sh_type == SH_ASR) ? FULL32 : OVER32;
      end
   end

endmodule

// File: rtl/shifter_operand_unit.sv
// Two-stage pipelined ARM shifter-operand unit: decode/capture in stage 1,
// shift and carry generation in stage 2, valid/ready on both sides with flush.
module shifter_operand_unit
   import shifter_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned AMT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] rm,
   input  logic [AMT_W-1:0]  amount,
   input  logic [1:0]        shift_type,
   input  logic              imm_form,
   input  logic              carry_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              carry_out
);

   shift_cls_e        dec_cls;
   logic [4:0]        dec_cnt;

   logic              s1_valid;
   shift_cls_e        s1_cls;
   shift_type_e       s1_type;
   logic [4:0]        s1_cnt;
   logic [DATA_W-1:0] s1_rm;
   logic              s1_cin;

   logic              s2_valid;
   logic              s2_adv;

   logic [DATA_W-1:0] nxt_res;
   logic              nxt_car;
   logic [4:0]        neg_idx;
   logic [4:0]        dec_idx;

   shift_decode #(.AMT_W(AMT_W)) u_decode (
      .amount     (amount),
      .shift_type (shift_type),
      .imm_form   (imm_form),
      .cls        (dec_cls),
      .count      (dec_cnt)
   );

   assign s2_adv    = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_cls   <= PASS;
         s1_type  <= SH_LSL;
         s1_cnt   <= '0;
         s1_rm    <= '0;
         s1_cin   <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cls  <= dec_cls;
            s1_type <= shift_type_e'(shift_type);
            s1_cnt  <= dec_cnt;
            s1_rm   <= rm;
            s1_cin  <= carry_in;
         end
      end
   end

   // For a count n in 1..31, 32-n wraps to -n in 5 bits
   assign neg_idx = 5'd0 - s1_cnt;
   assign dec_idx = s1_cnt - 5'd1;

   always_comb begin
      nxt_res = s1_rm;
      nxt_car = s1_cin;
      case (s1_cls)
         SHIFT: begin
            case (s1_type)
               SH_LSL: begin
                  nxt_res = s1_rm << s1_cnt;
                  nxt_car = s1_rm[neg_idx];
               end
               SH_LSR: begin
                  nxt_res = s1_rm >> s1_cnt;
                  nxt_car = s1_rm[dec_idx];
               end
               SH_ASR: begin
                  nxt_res = $signed(s1_rm) >>> s1_cnt;
                  nxt_car = s1_rm[dec_idx];
               end
               default: begin
                  nxt_res = (s1_rm >> s1_cnt) | (s1_rm << neg_idx);
                  nxt_car = s1_rm[dec_idx];
               end
            endcase
         end
         FULL32: begin
            case (s1_type)
               SH_LSL: begin
                  nxt_res = '0;
                  nxt_car = s1_rm[0];
               end
               SH_LSR: begin
                  nxt_res = '0;
                  nxt_car = s1_rm[DATA_W-1];
               end
               default: begin
                  nxt_res = {DATA_W{s1_rm[DATA_W-1]}};
                  nxt_car = s1_rm[DATA_W-1];
               end
            endcase
         end
         OVER32: begin
            nxt_res = '0;
            nxt_car = 1'b0;
         end
         RRX: begin
            nxt_res = {s1_cin, s1_rm[DATA_W-1:1]};
            nxt_car = s1_rm[0];
         end
         ROR0: begin
            nxt_res = s1_rm;
            nxt_car = s1_rm[DATA_W-1];
         end
         default: begin
            nxt_res = s1_rm;
            nxt_car = s1_cin;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result    <= nxt_res;
            carry_out <= nxt_car;
         end
      end
   end

endmodule
